// File: rtl/aes_dec_round_sequencer.sv
// Iterative AES decrypt sequencer: one inverse round per clock on a
// 128-bit state, round counter, round-key addressing, stream handshakes.
// Ports: inClk, inRstN (async, active low); inValid/outReady/inData
// block input; inKeyTop = key NUM_ROUNDS; outKeyIdx/inKey key store
// lookup (same-cycle); outValid/inReady/outData result; outBusy.
// Build option AES_DEC_SEQ_OUTBUF_EN: one-entry output register.
module aes_dec_round_sequencer #(
  parameter int NUM_ROUNDS = 14,
  parameter int KEY_IDX_W  = 4
) (
  input  logic                 inClk,
  input  logic                 inRstN,
  input  logic                 inValid,
  output logic                 outReady,
  input  logic [127:0]         inData,
  input  logic [127:0]         inKeyTop,
  output logic [KEY_IDX_W-1:0] outKeyIdx,
  input  logic [127:0]         inKey,
  output logic                 outValid,
  input  logic                 inReady,
  output logic [127:0]         outData,
  output logic                 outBusy
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Field inverse as a^254 (0 maps to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, s;
    p = 8'h01;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) p = gmul(p, s);
      s = gmul(s, s);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x,
                                      input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8)
  function automatic logic [7:0] isb(input logic [7:0] x);
    logic [7:0] y;
    y = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
    return ginv(y);
  endfunction

  // Byte n of the block sits at [127-8n -: 8], n = 4*col + row
  function automatic logic [127:0] inv_sub_shift(
    input logic [127:0] s);
    logic [127:0] o;
    logic [1:0] sc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sc = 2'(c - r);
        o[127-32*c-8*r -: 8] = isb(s[127-32*sc-8*r -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[127-32*c-8*r -: 8];
      for (int r = 0; r < 4; r++) begin
        o[127-32*c-8*r -: 8] = gmul(a[2'(r)], 8'h0e)
                             ^ gmul(a[2'(r+1)], 8'h0b)
                             ^ gmul(a[2'(r+2)], 8'h0d)
                             ^ gmul(a[2'(r+3)], 8'h09);
      end
    end
    return o;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } fsm_e;

  localparam logic [KEY_IDX_W-1:0] LastR =
    KEY_IDX_W'(NUM_ROUNDS - 1);

  fsm_e                 fsm_q, fsm_d;
  logic [KEY_IDX_W-1:0] r_q, r_d;
  logic [127:0]         st_q, st_d;
  logic [127:0]         pre, rnd;
  logic                 last;

  // Round 0 adds the top key up front; later rounds lead with
  // InvMixColumns. Both then share InvSubBytes/InvShiftRows/ARK.
  assign pre  = (r_q == '0) ? (st_q ^ inKeyTop) : inv_mix(st_q);
  assign rnd  = inv_sub_shift(pre) ^ inKey;
  assign last = (fsm_q == RUN) && (r_q == LastR);

  assign outReady  = (fsm_q == IDLE);
  assign outBusy   = (fsm_q != IDLE);
  assign outKeyIdx = (fsm_q == RUN) ? LastR - r_q : LastR;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      fsm_q <= IDLE;
      r_q   <= '0;
      st_q  <= '0;
    end else begin
      fsm_q <= fsm_d;
      r_q   <= r_d;
      st_q  <= st_d;
    end
  end

`ifdef AES_DEC_SEQ_OUTBUF_EN
  logic         ov_q, ov_d;
  logic [127:0] ob_q, ob_d;
  logic         free;

  assign free     = !ov_q || inReady;
  assign outValid = ov_q;
  assign outData  = ob_q;

  always_comb begin
    fsm_d = fsm_q;
    r_d   = r_q;
    st_d  = st_q;
    ov_d  = ov_q && !inReady;
    ob_d  = ob_q;
    unique case (fsm_q)
      IDLE: begin
        if (inValid) begin
          fsm_d = RUN;
          r_d   = '0;
          st_d  = inData;
        end
      end
      RUN: begin
        st_d = rnd;
        r_d  = r_q + KEY_IDX_W'(1);
        if (last) begin
          r_d = '0;
          if (free) begin
            ob_d  = rnd;
            ov_d  = 1'b1;
            fsm_d = IDLE;
          end else begin
            fsm_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (free) begin
          ob_d  = st_q;
          ov_d  = 1'b1;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      ov_q <= 1'b0;
      ob_q <= '0;
    end else begin
      ov_q <= ov_d;
      ob_q <= ob_d;
    end
  end
`else
  logic v_q, v_d;

  assign outValid = v_q;
  assign outData  = st_q;

  always_comb begin
    fsm_d = fsm_q;
    r_d   = r_q;
    st_d  = st_q;
    v_d   = v_q;
    unique case (fsm_q)
      IDLE: begin
        if (inValid) begin
          fsm_d = RUN;
          r_d   = '0;
          st_d  = inData;
        end
      end
      RUN: begin
        st_d = rnd;
        r_d  = r_q + KEY_IDX_W'(1);
        if (last) begin
          r_d   = '0;
          v_d   = 1'b1;
          fsm_d = HOLD;
        end
      end
      HOLD: begin
        if (inReady) begin
          v_d   = 1'b0;
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) v_q <= 1'b0;
    else         v_q <= v_d;
  end
`endif

endmodule

// File: tb/tb_aes_dec_round_sequencer.sv
// Bench for aes_dec_round_sequencer: AES-256 reference model,
// scoreboard queue, directed FIPS/trace/back-pressure/reset + random.
module tb_aes_dec_round_sequencer;
  localparam int NR = 14;
  localparam int KW = 4;
`ifdef AES_DEC_SEQ_OUTBUF_EN
  localparam int GAP = 15;
`else
  localparam int GAP = 16;
`endif
  localparam logic [255:0] FIPS_KEY =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic out_ready, out_valid, out_busy;
  logic [KW-1:0] key_idx;
  logic [127:0] out_data, key_top, key;
  logic [127:0] rk [0:NR];
  logic [7:0] sbt [256];
  logic [7:0] isbt [256];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc = -1;
  bit b2b = 1'b0;
  bit rand_rdy = 1'b0;

  typedef struct {
    logic [127:0] d;
    int acc;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb key_top = rk[NR];
  always_comb key = (int'(key_idx) <= NR) ? rk[key_idx] : '0;

  aes_dec_round_sequencer #(.NUM_ROUNDS(NR), .KEY_IDX_W(KW)) dut (
    .inClk(clk), .inRstN(rst_n), .inValid(in_valid), .outReady(out_ready),
    .inData(in_data), .inKeyTop(key_top), .outKeyIdx(key_idx), .inKey(key),
    .outValid(out_valid), .inReady(in_ready), .outData(out_data),
    .outBusy(out_busy));

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] binv(input logic [7:0] a);
    for (int b = 1; b < 256; b++)
      if (gm(a, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  task automatic build_tables();
    logic [7:0] x, y;
    for (int i = 0; i < 256; i++) begin
      x = binv(8'(i));
      y = x ^ rl(x, 1) ^ rl(x, 2) ^ rl(x, 3) ^ rl(x, 4) ^ 8'h63;
      sbt[i] = y;
      isbt[y] = 8'(i);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j <= NR; j++)
      rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  // Textbook inverse cipher on a byte matrix s[4*col+row]
  function automatic logic [127:0] ref_dec(input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int n = 0; n < 16; n++)
      s[n] = ct[127-8*n -: 8] ^ rk[NR][127-8*n -: 8];
    for (int rd = NR - 1; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = isbt[s[4*((c-r+4)%4)+r]] ^ rk[rd][127-8*(4*c+r) -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gm(8'h0e, t[4*c+r]) ^ gm(8'h0b, t[4*c+(r+1)%4])
                     ^ gm(8'h0d, t[4*c+(r+2)%4]) ^ gm(8'h09, t[4*c+(r+3)%4]);
      end else begin
        s = t;
      end
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && in_valid && out_ready) begin
      q.push_back('{d: ref_dec(in_data), acc: cyc + 1});
      if (b2b && last_acc >= 0) chki("b2b_gap", cyc + 1 - last_acc, GAP);
      last_acc = cyc + 1;
    end
  end

  bit pv = 1'b0;
  bit px = 1'b0;
  logic [127:0] pd = '0;
  always @(negedge clk) begin : mon_out
    exp_t e;
    if (!rst_n) begin
      pv = 1'b0;
      px = 1'b0;
    end else begin
      if (pv && !px) begin
        chki("hold_valid", int'(out_valid), 1);
        chk("hold_data", out_data, pd);
      end
      if (out_valid && (!pv || px) && q.size() != 0) begin
`ifdef AES_DEC_SEQ_OUTBUF_EN
        chki("latency_min", int'(cyc - q[0].acc >= NR), 1);
`else
        chki("latency", cyc - q[0].acc, NR);
`endif
      end
      if (out_valid && in_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: got %0h want none", out_data);
        end else begin
          e = q.pop_front();
          chk("data", out_data, e.d);
        end
      end
      pv = out_valid;
      px = out_valid && in_ready;
      pd = out_data;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #2;
      in_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] d, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!out_ready && waited < 300) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!out_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=0 want 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while ((out_busy || out_valid || q.size() != 0) && n < lim) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= lim) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0b valid=%0b pending=%0d want idle",
               out_busy, out_valid, q.size());
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] blk;
    int n;
    build_tables();
    expand(FIPS_KEY);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chki("rst_valid", int'(out_valid), 0);
    chk("rst_data", out_data, '0);
    chki("rst_busy", int'(out_busy), 0);
    chki("rst_keyidx", int'(key_idx), NR - 1);
    rst_n = 1'b1;
    @(negedge clk);
    chki("rst_ready", int'(out_ready), 1);

    // FIPS vector with key-index trace, inReady held low
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data = FIPS_CT;
    for (int s = 0; s <= NR + 1; s++) begin
      @(negedge clk);
      chki($sformatf("keyidx_%0d", s), int'(key_idx),
           (s == 0 || s == NR + 1) ? NR - 1 : NR - s);
      if (s == 0) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    chki("fips_valid", int'(out_valid), 1);
    chk("fips_data", out_data, FIPS_PT);

    // back-pressure for 20 cycles
    blk = rnd128();
    @(posedge clk);
    #1;
`ifndef AES_DEC_SEQ_OUTBUF_EN
    in_valid = 1'b1;
    in_data = blk;
`endif
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chki("bp_valid", int'(out_valid), 1);
      chk("bp_data", out_data, FIPS_PT);
`ifndef AES_DEC_SEQ_OUTBUF_EN
      chki("bp_ready", int'(out_ready), 0);
`endif
    end
    @(posedge clk);
    #1;
    in_ready = 1'b1;
    send(blk, n);
`ifndef AES_DEC_SEQ_OUTBUF_EN
    chki("accept_after_xfer", n, 1);
`endif
    wait_idle(100);

    // back-to-back with inValid held
    b2b = 1'b1;
    last_acc = -1;
    send(FIPS_CT, n);
    for (int i = 0; i < 3; i++) send(rnd128(), n);
    wait_idle(200);
    b2b = 1'b0;

    // reset at r=7
    send(rnd128(), n);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    q.delete();
    #1;
    chki("mid_rst_valid", int'(out_valid), 0);
    chki("mid_rst_busy", int'(out_busy), 0);
    chki("mid_rst_ready", int'(out_ready), 1);
    chk("mid_rst_data", out_data, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chki("post_rst_ready", int'(out_ready), 1);
    chki("post_rst_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    send(rnd128(), n);
    wait_idle(100);

`ifdef AES_DEC_SEQ_OUTBUF_EN
    // second block stalls in HOLD behind a full output buffer
    in_ready = 1'b0;
    send(rnd128(), n);
    send(rnd128(), n);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chki("stall_busy", int'(out_busy), 1);
    chki("stall_ready", int'(out_ready), 0);
    chki("stall_valid", int'(out_valid), 1);
    in_ready = 1'b1;
    wait_idle(100);
`endif

    // random key, random blocks, random back-pressure
    expand({$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom});
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      send(rnd128(), n);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #3;
    in_ready = 1'b1;
    wait_idle(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
